ps2_keypad_decoder: RTL
=======================

PS2_KEYPAD_DECODER -- requirements
Module: ps2_keypad_decoder

Interface
REQ-001 Parameter TIMEOUT_CYC, default 100000: clk cycles without a ps2_clk falling edge before a partial frame is aborted.
REQ-002 clk  input  1  system clock.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 ps2_clk  input  1  raw PS/2 clock from the keyboard; asynchronous to clk.
REQ-005 ps2_data  input  1  raw PS/2 data from the keyboard; asynchronous to clk.
REQ-006 key_ascii  output  8  calculator key code, held stable between pulses.
REQ-007 key_pressed  output  1  one-cycle strobe; key_ascii is valid while it is high.
REQ-008 frame_err  output  1  one-cycle strobe on a parity, stop-bit or timeout error.

Function
REQ-009 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge is the synchronized ps2_clk going 1->0 between consecutive cycles.
REQ-010 The receiver SHALL sample synchronized ps2_data on each falling edge and use states IDLE -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE: leaves only when the sampled bit is 0 (start); a sample of 1 stays in IDLE.
  - DATA: takes 8 bits, LSB first, counted by a 3-bit counter.
  - PARITY: the parity bit is sampled.
REQ-011 Frame check at STOP: the byte is valid only if the 8 data bits plus the parity bit have an odd number of ones and the stop bit is 1; otherwise frame_err pulses and the byte is discarded.
REQ-012 Timeout: a cycle counter clears on every falling edge; if the receiver is not in IDLE and the counter reaches TIMEOUT_CYC, the receiver returns to IDLE and frame_err pulses. If the timeout and an edge occur in the same cycle, the edge wins.
REQ-013 A valid byte SHALL be presented to the decoder for exactly one cycle, in the cycle after the stop-bit edge.
REQ-014 key_pressed SHALL assert exactly 2 cycles after the cycle in which the stop-bit falling edge is detected.
REQ-015 Decoder states: IDLE, BRK, EXT, EXT_BRK.
  - 0xF0 moves IDLE->BRK and EXT->EXT_BRK.
  - 0xE0 moves IDLE->EXT.
  - Any other byte is consumed and returns the decoder to IDLE.
REQ-016 Break codes (a byte consumed in BRK or EXT_BRK) SHALL never pulse key_pressed; only the shift flags are updated.
REQ-017 The shift flag is set by a make of 0x12 or 0x59 and cleared by a break of either; E0 12 and E0 59 are ignored.
REQ-018 Make map, non-extended, unshifted:
  - Digits '0'..'9': 45,16,1E,26,25,2E,36,3D,3E,46.
  - Operators: 4E '-'(45), 55 '='(61), 4A '/'(47).
  - Control: 5A Enter(10), 66 Backspace(8), 76 Esc(27).
REQ-019 Make map, non-extended, shifted: 55 -> '+'(43), 3E -> '*'(42); all other codes map as unshifted.
REQ-020 Make map, keypad, shift-independent:
  - Digits '0'..'9': 70,69,72,7A,6B,73,74,6C,75,7D.
  - Operators: 79 '+', 7B '-', 7C '*'.
REQ-021 Make map, extended (after E0): 4A -> '/', 5A -> 10; all other extended codes are unmapped.
REQ-022 An unmapped make code SHALL produce no pulse and SHALL leave key_ascii unchanged.
REQ-023 Typematic repeats (the same make code received again without a break) SHALL pulse again.
REQ-024 A frame error SHALL return the decoder to IDLE (pending prefixes dropped); the shift flag is kept.

Reset
REQ-025 While reset_n is low, all of the following hold:
  - key_ascii = 0x00, key_pressed = 0, frame_err = 0.
  - Receiver and decoder in IDLE, shift flag = 0, timeout counter = 0.
  - Synchronizer flops = 1 (bus idle).
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; after release, reception resumes at the next start bit with no spurious pulse.

Structure
REQ-027 A package ps2_kbd_pkg SHALL hold the receiver and decoder state enums, the scancode constants (F0, E0, the shift codes, the mapped codes) and the calculator ASCII constants (8, 10, 27, 42, 43, 45, 47, 48..57, 61).
REQ-028 The frame receiver (synchronizer, edge detect, timeout, parity check) SHALL be a sub-module ps2_rx with outputs rx_byte[7:0], rx_valid and rx_err.
REQ-029 ps2_keypad_decoder SHALL instantiate ps2_rx and implement the prefix/shift FSM and the code map.

Verification
REQ-030 Frame 0x16 (parity 0, stop 1) -> key_pressed for one cycle, key_ascii = 0x31, exactly 2 cycles after the stop edge.
REQ-031 Sequence 12, 55, F0 55, F0 12, 55:
  - First 55 -> one pulse, key_ascii = 0x2B.
  - Final 55 -> one pulse, key_ascii = 0x3D.
  - The break codes produce no pulse.
REQ-032 Sequence E0 4A, then E0 F0 4A -> exactly one pulse, key_ascii = 0x2F; then 76 -> one pulse, key_ascii = 0x1B.
REQ-033 Frame 0x16 with its parity bit flipped to 1 -> frame_err pulses once, no key_pressed, key_ascii unchanged.
REQ-034 Start bit plus 4 data bits, then idle for TIMEOUT_CYC cycles -> frame_err pulses once; a following valid 0x66 frame -> key_ascii = 0x08.
REQ-035 Unmapped make 0x1C -> no pulse; reset asserted mid-frame, then a valid 0x45 frame -> key_ascii = 0x30 with no extra pulses.

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 calculator keypad decoder:
// receiver/decoder state enums, scancodes, calculator ASCII codes and the
// make-code map.
package ps2_kbd_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {DEC_IDLE, DEC_BRK, DEC_EXT, DEC_EXT_BRK} dec_state_t;

  // Prefixes and shift keys
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  // Main-block make codes
  localparam logic [7:0] SC_0 = 8'h45, SC_1 = 8'h16, SC_2 = 8'h1E, SC_3 = 8'h26,
                         SC_4 = 8'h25, SC_5 = 8'h2E, SC_6 = 8'h36, SC_7 = 8'h3D,
                         SC_8 = 8'h3E, SC_9 = 8'h46;
  localparam logic [7:0] SC_MINUS = 8'h4E, SC_EQUAL = 8'h55, SC_SLASH = 8'h4A;
  localparam logic [7:0] SC_ENTER = 8'h5A, SC_BKSP  = 8'h66, SC_ESC   = 8'h76;

  // Keypad make codes
  localparam logic [7:0] KP_0 = 8'h70, KP_1 = 8'h69, KP_2 = 8'h72, KP_3 = 8'h7A,
                         KP_4 = 8'h6B, KP_5 = 8'h73, KP_6 = 8'h74, KP_7 = 8'h6C,
                         KP_8 = 8'h75, KP_9 = 8'h7D;
  localparam logic [7:0] KP_PLUS = 8'h79, KP_MINUS = 8'h7B, KP_STAR = 8'h7C;

  // Calculator ASCII codes
  localparam logic [7:0] ASC_BS    = 8'd8;
  localparam logic [7:0] ASC_LF    = 8'd10;
  localparam logic [7:0] ASC_ESC   = 8'd27;
  localparam logic [7:0] ASC_STAR  = 8'd42;
  localparam logic [7:0] ASC_PLUS  = 8'd43;
  localparam logic [7:0] ASC_MINUS = 8'd45;
  localparam logic [7:0] ASC_SLASH = 8'd47;
  localparam logic [7:0] ASC_0     = 8'd48;
  localparam logic [7:0] ASC_EQUAL = 8'd61;

  typedef struct packed {
    logic       hit;
    logic [7:0] ascii;
  } key_map_t;

  function automatic logic is_shift(input logic [7:0] code);
    return (code == SC_LSHIFT) || (code == SC_RSHIFT);
  endfunction

  // Make code -> calculator ASCII. hit=0 means unmapped.
  function automatic key_map_t map_make(input logic [7:0] code, input logic ext,
                                        input logic shift);
    key_map_t m;
    m.hit   = 1'b1;
    m.ascii = 8'h00;
    if (ext) begin
      case (code)
        SC_SLASH: m.ascii = ASC_SLASH;
        SC_ENTER: m.ascii = ASC_LF;
        default:  m.hit   = 1'b0;
      endcase
    end else begin
      case (code)
        SC_0, KP_0: m.ascii = ASC_0;
        SC_1, KP_1: m.ascii = ASC_0 + 8'd1;
        SC_2, KP_2: m.ascii = ASC_0 + 8'd2;
        SC_3, KP_3: m.ascii = ASC_0 + 8'd3;
        SC_4, KP_4: m.ascii = ASC_0 + 8'd4;
        SC_5, KP_5: m.ascii = ASC_0 + 8'd5;
        SC_6, KP_6: m.ascii = ASC_0 + 8'd6;
        SC_7, KP_7: m.ascii = ASC_0 + 8'd7;
        SC_8:       m.ascii = shift ? ASC_STAR : ASC_0 + 8'd8;
        KP_8:       m.ascii = ASC_0 + 8'd8;
        SC_9, KP_9: m.ascii = ASC_0 + 8'd9;
        SC_MINUS, KP_MINUS: m.ascii = ASC_MINUS;
        SC_EQUAL:   m.ascii = shift ? ASC_PLUS : ASC_EQUAL;
        KP_PLUS:    m.ascii = ASC_PLUS;
        KP_STAR:    m.ascii = ASC_STAR;
        SC_SLASH:   m.ascii = ASC_SLASH;
        SC_ENTER:   m.ascii = ASC_LF;
        SC_BKSP:    m.ascii = ASC_BS;
        SC_ESC:     m.ascii = ASC_ESC;
        default:    m.hit   = 1'b0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_keypad_decoder_if.sv
// Keyboard-side PS/2 lines plus the decoded key/error strobes.
interface ps2_keypad_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key_ascii;
  logic       key_pressed;
  logic       frame_err;

  // Keyboard / host side: drives the PS/2 lines, consumes keys
  modport master (output ps2_clk, ps2_data, input key_ascii, key_pressed, frame_err);
  // Decoder side
  modport slave  (input ps2_clk, ps2_data, output key_ascii, key_pressed, frame_err);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizes the raw lines, samples data on ps2_clk
// falling edges, checks odd parity and stop bit, aborts stale frames.
// rx_valid / rx_err are registered, so they appear the cycle after the
// stop-bit edge is detected.
module ps2_rx
  import ps2_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [1:0] clk_sync, dat_sync;
  logic       clk_prev;
  logic       fall, bit_in, timeout;

  rx_state_t        state, state_n;
  logic [7:0]       shreg, shreg_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic             par, par_n;
  logic             valid_n, err_n;
  logic [CNT_W-1:0] to_cnt;

  assign fall    = clk_prev & ~clk_sync[1];
  assign bit_in  = dat_sync[1];
  assign timeout = (state != RX_IDLE) && (to_cnt == CNT_W'(TIMEOUT_CYC)) && !fall;
  assign rx_byte = shreg;

  // Two-flop synchronizers (idle-high) plus a delayed copy for edge detect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      clk_prev <= clk_sync[1];
    end
  end

  // Inactivity counter: cleared by any edge, parked at 0 while idle,
  // saturates at the limit so the abort condition stays visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        to_cnt <= '0;
    else if (fall || state == RX_IDLE)   to_cnt <= '0;
    else if (to_cnt != CNT_W'(TIMEOUT_CYC)) to_cnt <= to_cnt + 1'b1;
  end

  // Receiver state and frame registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RX_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      par      <= 1'b0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bit_cnt  <= bit_cnt_n;
      par      <= par_n;
      rx_valid <= valid_n;
      rx_err   <= err_n;
    end
  end

  // Next-state: an edge always takes priority over the timeout
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    par_n     = par;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    if (fall) begin
      case (state)
        RX_IDLE: if (!bit_in) begin
          state_n   = RX_DATA;
          bit_cnt_n = '0;
        end
        RX_DATA: begin
          shreg_n   = {bit_in, shreg[7:1]};  // LSB arrives first
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = RX_PARITY;
        end
        RX_PARITY: begin
          par_n   = bit_in;
          state_n = RX_STOP;
        end
        RX_STOP: begin
          state_n = RX_IDLE;
          if ((^{shreg, par}) && bit_in) valid_n = 1'b1;
          else                           err_n   = 1'b1;
        end
        default: state_n = RX_IDLE;
      endcase
    end else if (timeout) begin
      state_n = RX_IDLE;
      err_n   = 1'b1;
    end
  end

endmodule

// File: rtl/ps2_keypad_decoder.sv
// PS/2 keyboard to calculator key decoder: tracks E0/F0 prefixes and the
// shift state, maps make codes to ASCII and strobes key_pressed.
module ps2_keypad_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  ps2_keypad_decoder_if.slave  bus
);
  logic [7:0] rx_byte;
  logic       rx_valid, rx_err;

  dec_state_t dec, dec_n;
  logic       shift, shift_n;
  logic       kp, kp_n;
  logic [7:0] ascii, ascii_n;
  key_map_t   km;

  ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk      (clk),
    .reset_n  (reset_n),
    .ps2_clk  (bus.ps2_clk),
    .ps2_data (bus.ps2_data),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_err   (rx_err)
  );

  assign km              = map_make(rx_byte, dec == DEC_EXT, shift);
  assign bus.key_ascii   = ascii;
  assign bus.key_pressed = kp;
  assign bus.frame_err   = rx_err;

  // Decoder state, shift flag and registered key outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec   <= DEC_IDLE;
      shift <= 1'b0;
      kp    <= 1'b0;
      ascii <= 8'h00;
    end else begin
      dec   <= dec_n;
      shift <= shift_n;
      kp    <= kp_n;
      ascii <= ascii_n;
    end
  end

  // Prefix/shift FSM; breaks only touch the shift flag, never pulse
  always_comb begin
    dec_n   = dec;
    shift_n = shift;
    kp_n    = 1'b0;
    ascii_n = ascii;
    if (rx_err) begin
      dec_n = DEC_IDLE;  // drop pending prefixes, keep shift
    end else if (rx_valid) begin
      case (dec)
        DEC_IDLE: begin
          if (rx_byte == SC_BRK)      dec_n = DEC_BRK;
          else if (rx_byte == SC_EXT) dec_n = DEC_EXT;
          else begin
            dec_n = DEC_IDLE;
            if (is_shift(rx_byte)) shift_n = 1'b1;
            if (km.hit) begin
              kp_n    = 1'b1;
              ascii_n = km.ascii;
            end
          end
        end
        DEC_EXT: begin
          if (rx_byte == SC_BRK) dec_n = DEC_EXT_BRK;
          else begin
            // Extended shift codes fall through the map unmapped
            dec_n = DEC_IDLE;
            if (km.hit) begin
              kp_n    = 1'b1;
              ascii_n = km.ascii;
            end
          end
        end
        DEC_BRK: begin
          dec_n = DEC_IDLE;
          if (is_shift(rx_byte)) shift_n = 1'b0;
        end
        DEC_EXT_BRK: dec_n = DEC_IDLE;
        default:     dec_n = DEC_IDLE;
      endcase
    end
  end

endmodule
